// File: rtl/preg_free_list_pkg.sv
// Shared types and sizing for the physical register free list.
// Contents:
//   preg_t     - physical register number
//   fl_ptr_t   - FIFO pointer: a wrap bit above the index
//   ckpt_tag_t - branch checkpoint slot index
package preg_free_list_pkg;

  localparam int NUM_PREGS    = 128;
  localparam int NUM_AREGS    = 32;
  localparam int PREG_W       = 7;
  localparam int CKPT_N       = 4;
  localparam int CKPT_W       = 2;
  localparam int FL_DEPTH     = NUM_PREGS;
  // p0..p31 hold the initial architectural mappings, so they start out allocated.
  localparam int FL_INIT_FREE = NUM_PREGS - NUM_AREGS;

  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [PREG_W:0]   fl_ptr_t;
  typedef logic [CKPT_W-1:0] ckpt_tag_t;

endpackage

// File: rtl/preg_free_list_if.sv
// Signal bundle between the free list and its clients (rename, commit and
// the branch-mispredict network).
//
// Handshake semantics:
//   alloc_req/alloc_gnt - rename raises alloc_req and samples alloc_gnt in the
//     same cycle. When alloc_gnt is high, alloc_preg is consumed and the
//     next free register is shown from the following cycle on. alloc_preg
//     is meaningful whenever empty is low.
//   free_valid - one-sided. The free list never back-pressures commit. A
//     return that arrives while the list is full is dropped, and
//     err_overflow is raised and held.
//   ckpt_save / mispredict - single-cycle strobes qualified by their tags.
//     When both are high, mispredict wins.
//
// Modports: master = the clients, slave = the free list itself.
interface preg_free_list_if;
  import preg_free_list_pkg::*;

  logic      alloc_req;
  preg_t     alloc_preg;
  logic      alloc_gnt;
  logic      empty;
  logic      free_valid;
  preg_t     free_preg;
  logic      ckpt_save;
  ckpt_tag_t ckpt_tag;
  logic      mispredict;
  ckpt_tag_t mispredict_tag;
  fl_ptr_t   free_count;
  logic      err_overflow;

  modport master (
    output alloc_req, free_valid, free_preg, ckpt_save, ckpt_tag,
           mispredict, mispredict_tag,
    input  alloc_preg, alloc_gnt, empty, free_count, err_overflow
  );

  modport slave (
    input  alloc_req, free_valid, free_preg, ckpt_save, ckpt_tag,
           mispredict, mispredict_tag,
    output alloc_preg, alloc_gnt, empty, free_count, err_overflow
  );

endinterface

// File: rtl/preg_free_list.sv
// Free list for the 128-entry physical register file. It is a circular FIFO
// of register numbers. The head feeds rename and the tail takes returns
// from commit. The head pointer can be snapshotted into checkpoint slots and
// restored on a mispredict.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-low reset
//   fl    - preg_free_list_if.slave (alloc, free, checkpoint, status)
module preg_free_list
  import preg_free_list_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  preg_free_list_if.slave   fl
);

  preg_t   storage [FL_DEPTH];
  fl_ptr_t ckpt    [CKPT_N];
  fl_ptr_t head;
  fl_ptr_t tail;
  fl_ptr_t count;
  fl_ptr_t head_adv;
  logic    empty;
  logic    full;
  logic    gnt;
  logic    free_live;
  logic    free_ok;
  logic    free_drop;
  logic    err_q;

  // With the wrap bit, a plain subtraction yields 0..128 without ambiguity.
  assign count = tail - head;
  assign empty = (count == '0);
  assign full  = (count == fl_ptr_t'(FL_DEPTH));

  // No grant is given while reset is held. This keeps alloc_gnt at 0 as soon
  // as reset is asserted, even if rename is still requesting.
  assign gnt = fl.alloc_req & ~empty & ~fl.mispredict & reset;

  // This is the head after this cycle's grant. A checkpoint captures this
  // value, so the allocation in the checkpoint cycle belongs to the older path.
  assign head_adv = head + fl_ptr_t'(gnt);

  // p0 is never recycled. A return of 0 is neither queued nor an overflow.
  assign free_live = fl.free_valid & (fl.free_preg != '0);
  assign free_ok   = free_live & ~full;
  assign free_drop = free_live & full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= fl_ptr_t'(FL_INIT_FREE);
      err_q <= 1'b0;
      for (int i = 0; i < CKPT_N; i++) begin
        ckpt[i] <= '0;
      end
    end else begin
      // The tail is never rolled back. Frees come from commit and are older
      // than any branch that can still mispredict.
      head <= fl.mispredict ? ckpt[fl.mispredict_tag] : head_adv;
      if (free_ok) begin
        tail <= tail + 1'b1;
      end
      if (free_drop) begin
        err_q <= 1'b1;
      end
      if (fl.ckpt_save && !fl.mispredict) begin
        ckpt[fl.ckpt_tag] <= head_adv;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FL_DEPTH; i++) begin
        storage[i] <= (i < FL_INIT_FREE) ? preg_t'(i + NUM_AREGS) : '0;
      end
    end else if (free_ok) begin
      storage[tail[PREG_W-1:0]] <= fl.free_preg;
    end
  end

  // This is a show-ahead read. A same-cycle free into an empty list is not
  // forwarded; it shows up here in the next cycle.
  assign fl.alloc_preg   = storage[head[PREG_W-1:0]];
  assign fl.alloc_gnt    = gnt;
  assign fl.empty        = empty;
  assign fl.free_count   = count;
  assign fl.err_overflow = err_q;

endmodule
